// File: rtl/hdmi_di_pkg.sv
// Shared encodings, packet layout and BCH step for the HDMI data-island transmitter.
package hdmi_di_pkg;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'd0,
    MODE_PRE   = 2'd1,
    MODE_GUARD = 2'd2,
    MODE_DATA  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PRE,
    ST_LGB,
    ST_PKT,
    ST_TGB
  } state_e;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PKT_CYCLES   = 32;
  localparam int HDR_BITS     = 24;
  localparam int SUB_BITS     = 56;

  localparam logic [7:0] BCH_POLY = 8'hC1;

  typedef struct packed {
    logic [23:0]  header;
    logic [223:0] body;
  } pkt_t;

  // One serial step of the BCH(x^8+x^7+x^6+1) encoder.
  function automatic logic [7:0] bch_step(input logic [7:0] code, input logic bit_in);
    return {code[6:0], 1'b0} ^ ((code[7] ^ bit_in) ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/hdmi_data_island_tx_if.sv
// Packet push bus between packet generators (master) and the data-island transmitter (slave).
interface hdmi_data_island_tx_if #(
  parameter int DEPTH = 8
);
  logic                   pkt_valid;
  logic [23:0]            pkt_header;
  logic [223:0]           pkt_body;
  logic                   pkt_ready;
  logic [$clog2(DEPTH):0] level;

  modport master (
    output pkt_valid, pkt_header, pkt_body,
    input  pkt_ready, level
  );

  modport slave (
    input  pkt_valid, pkt_header, pkt_body,
    output pkt_ready, level
  );
endinterface

// File: rtl/hdmi_bch_lane.sv
// One BCH ECC lane: passes data bits through while accumulating parity, then shifts parity out MSB first.
module hdmi_bch_lane #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic                      first,
  input  logic                      par,
  input  logic [BITS_PER_CYCLE-1:0] din,
  output logic [BITS_PER_CYCLE-1:0] dout
);
  import hdmi_di_pkg::*;

  logic [7:0] code;
  logic [7:0] base;
  logic [7:0] code_nx;

  // The register restarts from zero on the first cycle of every packet, so it needs no reset.
  always_comb begin
    base    = first ? 8'h00 : code;
    code_nx = base;
    dout    = din;
    if (par) begin
      code_nx = base << BITS_PER_CYCLE;
      for (int i = 0; i < BITS_PER_CYCLE; i++) dout[i] = base[7-i];
    end else begin
      for (int i = 0; i < BITS_PER_CYCLE; i++) code_nx = bch_step(code_nx, din[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (en) code <= code_nx;
  end

endmodule

// File: rtl/hdmi_data_island_tx.sv
// HDMI data-island transmitter: packet FIFO, island sequencer and TERC4 nibble generation with BCH ECC.
module hdmi_data_island_tx #(
  parameter int DEPTH         = 8,
  parameter int MAX_PKTS      = 4,
  parameter int ISLAND_OFFSET = 12
) (
  input  logic                       i_pixclk,
  input  logic                       i_reset,
  input  logic                       i_hSync,
  input  logic                       i_vSync,
  input  logic                       i_blank,
  hdmi_data_island_tx_if.slave       pkt,
  output logic [3:0]                 o_d0,
  output logic [3:0]                 o_d1,
  output logic [3:0]                 o_d2,
  output logic [1:0]                 o_mode,
  output logic                       o_busy
);
  import hdmi_di_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int CNT_W = ($clog2(ISLAND_OFFSET) > 5) ? $clog2(ISLAND_OFFSET) : 5;

  pkt_t             mem [DEPTH];
  pkt_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count, count_nx;
  logic             ready;
  logic             push, pop;

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [4:0]       pidx, pidx_nx;
  logic [4:0]       npk, npk_nx;
  logic             blank_q;
  logic             abort;

  logic [4:0]       c;
  logic             emit, first_c, hdr_par, sub_par;
  logic [31:0]      hdr_pad;
  logic             hdr_out;
  logic [1:0]       sub_out [4];

  mode_e            mode_nx;
  logic [3:0]       d0_nx, d1_nx, d2_nx;

  assign push          = pkt.pkt_valid && ready;
  assign count_nx      = count + LW'(push) - LW'(pop);
  assign head          = mem[rd_ptr];
  assign pkt.pkt_ready = ready;
  assign pkt.level     = count;

  always_ff @(posedge i_pixclk) begin
    if (push) begin
      mem[wr_ptr].header <= pkt.pkt_header;
      mem[wr_ptr].body   <= pkt.pkt_body;
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      ready <= (count_nx != LW'(DEPTH));
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pidx    <= '0;
      npk     <= '0;
      blank_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pidx    <= pidx_nx;
      npk     <= npk_nx;
      blank_q <= i_blank;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pidx_nx  = pidx;
    npk_nx   = npk;
    abort    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_blank && !blank_q) begin
          state_nx = ST_WAIT;
          cnt_nx   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(ISLAND_OFFSET - 2)) begin
          cnt_nx = '0;
          if (count == '0) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_PRE;
            npk_nx   = (int'(count) >= MAX_PKTS) ? 5'(MAX_PKTS) : 5'(count);
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_PRE: begin
        if (cnt == CNT_W'(PREAMBLE_LEN - 1)) begin
          state_nx = ST_LGB;
          cnt_nx   = '0;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      ST_LGB: begin
        if (cnt == CNT_W'(GUARD_LEN - 1)) begin
          state_nx = ST_PKT;
          cnt_nx   = '0;
          pidx_nx  = '0;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      ST_PKT: begin
        if (cnt == CNT_W'(PKT_CYCLES - 1)) begin
          cnt_nx = '0;
          if (pidx + 5'd1 == npk) state_nx = ST_TGB;
          else                    pidx_nx  = pidx + 5'd1;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      ST_TGB: begin
        if (cnt == CNT_W'(GUARD_LEN - 1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
    // Losing blank mid-island drops everything; the unpopped head goes out again next line.
    if (state != ST_IDLE && !i_blank) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      abort    = 1'b1;
    end
  end

  // Outputs are built from the next state so they line up with the state register.
  assign c       = cnt_nx[4:0];
  assign emit    = (state_nx == ST_PKT);
  assign first_c = (c == 5'd0);
  assign hdr_par = (c >= 5'(HDR_BITS));
  assign sub_par = (c >= 5'(SUB_BITS / 2));
  assign pop     = emit && (c == 5'(PKT_CYCLES - 1));
  assign hdr_pad = {8'h00, head.header};

  hdmi_bch_lane #(.BITS_PER_CYCLE(1)) u_hdr_lane (
    .clk   (i_pixclk),
    .en    (emit),
    .first (first_c),
    .par   (hdr_par),
    .din   (hdr_pad[c]),
    .dout  (hdr_out)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sub
    logic [63:0] sub_pad;
    assign sub_pad = {8'h00, head.body[SUB_BITS*k +: SUB_BITS]};
    hdmi_bch_lane #(.BITS_PER_CYCLE(2)) u_sub_lane (
      .clk   (i_pixclk),
      .en    (emit),
      .first (first_c),
      .par   (sub_par),
      .din   (sub_pad[{c, 1'b0} +: 2]),
      .dout  (sub_out[k])
    );
  end

  always_comb begin
    mode_nx = MODE_CTRL;
    d0_nx   = {2'b00, i_vSync, i_hSync};
    d1_nx   = 4'h0;
    d2_nx   = 4'h0;
    case (state_nx)
      ST_PRE: mode_nx = MODE_PRE;
      ST_LGB, ST_TGB: begin
        mode_nx = MODE_GUARD;
        d0_nx   = {2'b11, i_vSync, i_hSync};
      end
      ST_PKT: begin
        mode_nx = MODE_DATA;
        d0_nx   = {!(first_c && pidx_nx == 5'd0), hdr_out, i_vSync, i_hSync};
        d1_nx   = {sub_out[3][0], sub_out[2][0], sub_out[1][0], sub_out[0][0]};
        d2_nx   = {sub_out[3][1], sub_out[2][1], sub_out[1][1], sub_out[0][1]};
      end
      default: ;
    endcase
    if (abort) d0_nx = 4'h0;
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      o_mode <= MODE_CTRL;
      o_d0   <= 4'h0;
      o_d1   <= 4'h0;
      o_d2   <= 4'h0;
      o_busy <= 1'b0;
    end else begin
      o_mode <= mode_nx;
      o_d0   <= d0_nx;
      o_d1   <= d1_nx;
      o_d2   <= d2_nx;
      o_busy <= (state_nx != ST_IDLE);
    end
  end

endmodule
